jtag_mem_cmd: RTL and testbench

- Initiator side of the debug memory-access path.
- Accepts decoded debug commands from the JTAG TAP data register, already in the core clock domain.
- Sequences them into single-cycle imem/dmem read/write strobes on the processor debug memory port.
- Captures read data after a fixed memory latency and returns one response per word to the TAP.

---
 rtl/jtag_mem_cmd.sv | 229 ++++++++++++++++++++++
 tb/tb_jtag_mem_cmd.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_mem_cmd.sv
// rtl/jtag_mem_cmd.sv - debug memory-access initiator: sequences TAP commands into imem/dmem strobes and returns one response per word
// Optional burst support is enabled by defining JTAG_MEM_CMD_AUTOINC_EN; without it every command is a single word.
module jtag_mem_cmd #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_write,
    output logic                  imem_re,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_data_w,
    input  logic [DATA_WIDTH-1:0] imem_data_r,
    output logic                  dmem_re,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_data_w,
    input  logic [DATA_WIDTH-1:0] dmem_data_r
);

    // Latency counter only needs to hold RD_LATENCY-1.
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_write_q, rsp_write_d;
    logic                  imem_re_q, imem_re_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_data_w_q, imem_data_w_d;
    logic                  dmem_re_q, dmem_re_d;
    logic                  dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_WIDTH-1:0] dmem_data_w_q, dmem_data_w_d;

    // Word issue request shared by command acceptance and burst continuation.
    logic                  do_issue;
    logic [1:0]            issue_op;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [DATA_WIDTH-1:0] issue_data;
    logic [CNT_WIDTH-1:0]  start_remaining;

`ifdef JTAG_MEM_CMD_AUTOINC_EN
    assign start_remaining = cmd_count;
`else
    // Single-word build: the burst length field is present but ignored.
    logic unused_cmd_count;
    assign unused_cmd_count = ^cmd_count;
    assign start_remaining  = '0;
`endif

    // Next-state and next-output computation for the command sequencer.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cur_addr_d    = cur_addr_q;
        data_d        = data_q;
        remaining_d   = remaining_q;
        lat_cnt_d     = lat_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_write_d   = rsp_write_q;
        imem_re_d     = 1'b0;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_data_w_d = imem_data_w_q;
        dmem_re_d     = 1'b0;
        dmem_we_d     = 1'b0;
        dmem_addr_d   = dmem_addr_q;
        dmem_data_w_d = dmem_data_w_q;
        do_issue      = 1'b0;
        issue_op      = op_q;
        issue_addr    = cur_addr_q;
        issue_data    = data_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is low in the first cycle after reset, so no accept there.
                if (cmd_ready_q && cmd_valid) begin
                    op_d        = cmd_op;
                    cur_addr_d  = cmd_addr;
                    data_d      = cmd_data;
                    remaining_d = start_remaining;
                    do_issue    = 1'b1;
                    issue_op    = cmd_op;
                    issue_addr  = cmd_addr;
                    issue_data  = cmd_data;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_q[0]) begin
                    rsp_data_d  = '0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    lat_cnt_d = LAT_W'(RD_LATENCY - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rsp_data_d  = op_q[1] ? dmem_data_r : imem_data_r;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (remaining_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                        remaining_d = remaining_q - CNT_WIDTH'(1);
                        do_issue    = 1'b1;
                        issue_addr  = cur_addr_q + ADDR_WIDTH'(1);
                        state_d     = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Only the port picked by op[1] strobes; write data only moves on writes.
        if (do_issue) begin
            if (issue_op[1]) begin
                dmem_re_d   = ~issue_op[0];
                dmem_we_d   = issue_op[0];
                dmem_addr_d = issue_addr;
                if (issue_op[0]) dmem_data_w_d = issue_data;
            end else begin
                imem_re_d   = ~issue_op[0];
                imem_we_d   = issue_op[0];
                imem_addr_d = issue_addr;
                if (issue_op[0]) imem_data_w_d = issue_data;
            end
        end

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            op_q          <= 2'b00;
            cur_addr_q    <= '0;
            data_q        <= '0;
            remaining_q   <= '0;
            lat_cnt_q     <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_write_q   <= 1'b0;
            imem_re_q     <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_data_w_q <= '0;
            dmem_re_q     <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_data_w_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cur_addr_q    <= cur_addr_d;
            data_q        <= data_d;
            remaining_q   <= remaining_d;
            lat_cnt_q     <= lat_cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_write_q   <= rsp_write_d;
            imem_re_q     <= imem_re_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_data_w_q <= imem_data_w_d;
            dmem_re_q     <= dmem_re_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_data_w_q <= dmem_data_w_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_write   = rsp_write_q;
    assign imem_re     = imem_re_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_data_w = imem_data_w_q;
    assign dmem_re     = dmem_re_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_data_w = dmem_data_w_q;

endmodule

// File: tb/tb_jtag_mem_cmd.sv
// tb/tb_jtag_mem_cmd.sv - directed self-checking bench for jtag_mem_cmd with a two-cycle latency memory model
module tb_jtag_mem_cmd;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [CW-1:0] cmd_count;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_write;
    logic          imem_re, imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data_w, imem_data_r;
    logic          dmem_re, dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_data_w, dmem_data_r;

    int vectors     = 0;
    int miscompares = 0;

    jtag_mem_cmd #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RD_LATENCY(LAT),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_count  (cmd_count),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_write  (rsp_write),
        .imem_re    (imem_re),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_data_w(imem_data_w),
        .imem_data_r(imem_data_r),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_data_w(dmem_data_w),
        .dmem_data_r(dmem_data_r)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears LAT cycles after the strobe cycle, garbage otherwise.
    // dmem word = addr ^ 0x12345658, imem word = ~addr.
    logic [1:0]    d_vld, i_vld;
    logic [AW-1:0] d_a0, d_a1, i_a0, i_a1;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_vld <= 2'b00;
            i_vld <= 2'b00;
            d_a0  <= '0;
            d_a1  <= '0;
            i_a0  <= '0;
            i_a1  <= '0;
        end else begin
            d_vld <= {d_vld[0], dmem_re};
            i_vld <= {i_vld[0], imem_re};
            d_a0  <= dmem_addr;
            d_a1  <= d_a0;
            i_a0  <= imem_addr;
            i_a1  <= i_a0;
        end
    end
    assign dmem_data_r = d_vld[1] ? (d_a1 ^ 32'h1234_5658) : 32'hBAD0_BAD0;
    assign imem_data_r = i_vld[1] ? ~i_a1 : 32'hBAD1_BAD1;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [7:0] cnt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_count = cnt;
    endtask

    logic [31:0] we_addr [8];
    logic [31:0] exp_addr [4];
    int          n_we, n_rsp, n_bad, n_badrsp, n_exp;

    initial begin
        // Reset held with a command offered
        reset     = 1'b0;
        rsp_ready = 1'b0;
        send(2'd1, 32'h10, 32'h1111_1111, 8'd0);
        tick();
        tick();
        chk1("rst_imem_re", imem_re, 1'b0);
        chk1("rst_imem_we", imem_we, 1'b0);
        chk1("rst_dmem_re", dmem_re, 1'b0);
        chk1("rst_dmem_we", dmem_we, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chk32("rst_imem_addr", imem_addr, 32'h0);
        chk32("rst_dmem_data_w", dmem_data_w, 32'h0);
        chk32("rst_rsp_data", rsp_data, 32'h0);
        chk1("rst_rsp_write", rsp_write, 1'b0);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        chk1("rel_cmd_ready_pre_edge", cmd_ready, 1'b0);
        tick();
        chk1("rel_cmd_ready", cmd_ready, 1'b1);

        // Single imem write
        send(2'd1, 32'h10, 32'hDEAD_BEEF, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk1("wr_imem_we", imem_we, 1'b1);
        chk1("wr_imem_re", imem_re, 1'b0);
        chk32("wr_imem_addr", imem_addr, 32'h10);
        chk32("wr_imem_data_w", imem_data_w, 32'hDEAD_BEEF);
        chk1("wr_dmem_we", dmem_we, 1'b0);
        chk1("wr_dmem_re", dmem_re, 1'b0);
        chk1("wr_cmd_ready_busy", cmd_ready, 1'b0);
        chk1("wr_rsp_valid_early", rsp_valid, 1'b0);
        tick();
        chk1("wr_imem_we_drop", imem_we, 1'b0);
        chk1("wr_rsp_valid", rsp_valid, 1'b1);
        chk1("wr_rsp_write", rsp_write, 1'b1);
        chk32("wr_rsp_data", rsp_data, 32'h0);
        chk32("wr_imem_addr_hold", imem_addr, 32'h10);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk1("wr_done_rsp_valid", rsp_valid, 1'b0);
        chk1("wr_done_cmd_ready", cmd_ready, 1'b1);

        // dmem read, rsp_ready held high throughout (ignored until rsp_valid)
        send(2'd2, 32'h20, 32'h5555_5555, 8'd0);
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        chk1("rd_dmem_re", dmem_re, 1'b1);
        chk32("rd_dmem_addr", dmem_addr, 32'h20);
        chk1("rd_imem_re", imem_re, 1'b0);
        chk1("rd_dmem_we", dmem_we, 1'b0);
        tick();
        chk1("rd_s1_rsp_valid", rsp_valid, 1'b0);
        chk1("rd_s1_dmem_re", dmem_re, 1'b0);
        tick();
        chk1("rd_s2_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk1("rd_s3_rsp_valid", rsp_valid, 1'b1);
        chk32("rd_rsp_data", rsp_data, 32'h1234_5678);
        chk1("rd_rsp_write", rsp_write, 1'b0);
        tick();
        rsp_ready = 1'b0;
        chk1("rd_done_cmd_ready", cmd_ready, 1'b1);
        chk1("rd_done_rsp_valid", rsp_valid, 1'b0);

        // imem read with 5 cycles of backpressure
        send(2'd0, 32'h30, 32'h0, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk1("bp_imem_re", imem_re, 1'b1);
        chk32("bp_imem_addr", imem_addr, 32'h30);
        tick();
        tick();
        tick();
        chk1("bp_rsp_valid", rsp_valid, 1'b1);
        chk32("bp_rsp_data", rsp_data, 32'hFFFF_FFCF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("bp_hold_rsp_valid", rsp_valid, 1'b1);
            chk32("bp_hold_rsp_data", rsp_data, 32'hFFFF_FFCF);
            chk1("bp_hold_no_strobe", imem_re | imem_we | dmem_re | dmem_we, 1'b0);
            chk1("bp_hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk1("bp_release_cmd_ready", cmd_ready, 1'b1);
        chk1("bp_release_rsp_valid", rsp_valid, 1'b0);

        // dmem write burst across the address wrap
        exp_addr[0] = 32'hFFFF_FFFE;
        exp_addr[1] = 32'hFFFF_FFFF;
        exp_addr[2] = 32'h0000_0000;
        exp_addr[3] = 32'h0000_0001;
`ifdef JTAG_MEM_CMD_AUTOINC_EN
        n_exp = 4;
`else
        n_exp = 1;
`endif
        n_we = 0; n_rsp = 0; n_bad = 0; n_badrsp = 0;
        send(2'd3, 32'hFFFF_FFFE, 32'hA5A5_0F0F, 8'd3);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            cmd_valid = 1'b0;
            if (dmem_we) begin
                if (n_we < 8) we_addr[n_we] = dmem_addr;
                n_we++;
            end
            if (imem_we | imem_re | dmem_re) n_bad++;
            if (rsp_valid) begin
                n_rsp++;
                if (rsp_write !== 1'b1 || rsp_data !== 32'h0) n_badrsp++;
            end
        end
        rsp_ready = 1'b0;
        chk32("burst_we_count", n_we, n_exp);
        chk32("burst_rsp_count", n_rsp, n_exp);
        chk32("burst_other_strobes", n_bad, 0);
        chk32("burst_bad_rsp", n_badrsp, 0);
        for (int i = 0; i < n_exp; i++) chk32("burst_addr", we_addr[i], exp_addr[i]);
        chk32("burst_data_w", dmem_data_w, 32'hA5A5_0F0F);
        chk1("burst_done_cmd_ready", cmd_ready, 1'b1);

        // Reset during WAIT of a dmem read discards the read
        send(2'd2, 32'h24, 32'h0, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk1("rw_dmem_re", dmem_re, 1'b1);
        tick();
        rsp_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk1("rw_rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rw_rst_cmd_ready", cmd_ready, 1'b0);
        chk1("rw_rst_dmem_re", dmem_re, 1'b0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("rw_no_rsp", rsp_valid, 1'b0);
            chk1("rw_no_strobe", dmem_re | imem_re, 1'b0);
        end
        rsp_ready = 1'b0;
        chk1("rw_cmd_ready", cmd_ready, 1'b1);
        send(2'd1, 32'h4, 32'hCAFE_F00D, 8'd0);
        tick();
        cmd_valid = 1'b0;
        chk1("rw_wr_imem_we", imem_we, 1'b1);
        chk32("rw_wr_imem_addr", imem_addr, 32'h4);
        chk32("rw_wr_imem_data_w", imem_data_w, 32'hCAFE_F00D);
        tick();
        chk1("rw_wr_rsp_valid", rsp_valid, 1'b1);
        chk1("rw_wr_rsp_write", rsp_write, 1'b1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk1("rw_wr_cmd_ready", cmd_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
